hazard_scoreboard: RTL



---
 rtl/hazard_pkg.sv | 32 +++
 rtl/hazard_scoreboard_if.sv | 39 +++
 rtl/md_busy_counter.sv | 31 +++
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared widths, Tuse/Tnew encodings and forward-select codes for the hazard unit.
package hazard_pkg;

    localparam int unsigned REG_AW_DEF   = 5;
    localparam int unsigned STAGES_DEF   = 3;
    localparam int unsigned TW_DEF       = 2;
    localparam int unsigned MULT_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF  = 10;

    // Width of a forward select able to name GRF (0) plus every tracked stage.
    function automatic int unsigned sel_width(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

    localparam int unsigned SEL_W_DEF = sel_width(STAGES_DEF);

    // Cycles from D until an operand is consumed.
    localparam logic [TW_DEF-1:0] TUSE_D = 2'd0;
    localparam logic [TW_DEF-1:0] TUSE_E = 2'd1;
    localparam logic [TW_DEF-1:0] TUSE_M = 2'd2;

    // Cycles after entering E until a result exists.
    localparam logic [TW_DEF-1:0] TNEW_0 = 2'd0;
    localparam logic [TW_DEF-1:0] TNEW_1 = 2'd1;
    localparam logic [TW_DEF-1:0] TNEW_2 = 2'd2;

    localparam logic [SEL_W_DEF-1:0] FWD_GRF = 2'd0;
    localparam logic [SEL_W_DEF-1:0] FWD_E   = 2'd1;
    localparam logic [SEL_W_DEF-1:0] FWD_M   = 2'd2;
    localparam logic [SEL_W_DEF-1:0] FWD_W   = 2'd3;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage view of the hazard unit: decoder fields in, stall/forward/busy out.
interface hazard_scoreboard_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned TW     = 2,
    parameter int unsigned SEL_W  = 2
);

    logic [REG_AW-1:0] D_rs;
    logic [REG_AW-1:0] D_rt;
    logic              D_rs_use;
    logic              D_rt_use;
    logic [TW-1:0]     D_rs_Tuse;
    logic [TW-1:0]     D_rt_Tuse;
    logic [REG_AW-1:0] D_A3;
    logic [TW-1:0]     D_Tnew;
    logic              D_md_start;
    logic              D_md_div;
    logic              D_md_use;

    logic              stall;
    logic [SEL_W-1:0]  fwd_rs_sel;
    logic [SEL_W-1:0]  fwd_rt_sel;
    logic              md_busy;

    // Decoder side.
    modport master (
        output D_rs, D_rt, D_rs_use, D_rt_use, D_rs_Tuse, D_rt_Tuse,
               D_A3, D_Tnew, D_md_start, D_md_div, D_md_use,
        input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
    );

    // Hazard unit side.
    modport slave (
        input  D_rs, D_rt, D_rs_use, D_rt_use, D_rs_Tuse, D_rt_Tuse,
               D_A3, D_Tnew, D_md_start, D_md_div, D_md_use,
        output stall, fwd_rs_sel, fwd_rt_sel, md_busy
    );

endinterface

// File: rtl/md_busy_counter.sv
// Tracks how many cycles the multi-cycle mult/div unit stays occupied.
module md_busy_counter #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_div,
    output logic o_busy
);

    localparam int unsigned MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    logic [CW-1:0] r_cnt;

    // Load on an accepted mult/div, otherwise count down and rest at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-stage (dest, Tnew) scoreboard driving the global stall and D-stage forward selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned STAGES   = STAGES_DEF,
    parameter int unsigned TW       = TW_DEF,
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
    input  logic          clk,
    input  logic          reset,
    hazard_scoreboard_if.slave hz
);

    localparam int unsigned SEL_W = sel_width(STAGES);

    // Entry k describes the instruction currently in stage k (1 = E).
    logic              r_valid [1:STAGES];
    logic [REG_AW-1:0] r_a3    [1:STAGES];
    logic [TW-1:0]     r_tnew  [1:STAGES];

    logic             w_rs_hit;
    logic [SEL_W-1:0] w_rs_idx;
    logic [TW-1:0]    w_rs_tnew;
    logic             w_rt_hit;
    logic [SEL_W-1:0] w_rt_idx;
    logic [TW-1:0]    w_rt_tnew;
    logic             w_rs_hazard;
    logic             w_rt_hazard;
    logic             w_md_hazard;
    logic             w_md_busy;
    logic             w_stall;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // Shift entries down every edge; stalls only inject a bubble at the head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_a3[k]    <= '0;
                r_tnew[k]  <= '0;
            end
        end else begin
            r_valid[1] <= !w_stall && (hz.D_A3 != '0);
            r_a3[1]    <= w_stall ? '0 : hz.D_A3;
            r_tnew[1]  <= w_stall ? '0 : hz.D_Tnew;
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k+1] <= r_valid[k];
                r_a3[k+1]    <= r_a3[k];
                r_tnew[k+1]  <= sat_dec(r_tnew[k]);
            end
        end
    end

    // Youngest-match priority encoder: scan oldest to youngest so the youngest wins.
    always_comb begin
        w_rs_hit  = 1'b0;
        w_rs_idx  = '0;
        w_rs_tnew = '0;
        w_rt_hit  = 1'b0;
        w_rt_idx  = '0;
        w_rt_tnew = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (hz.D_rs_use && (hz.D_rs != '0) && r_valid[k] && (r_a3[k] == hz.D_rs)) begin
                w_rs_hit  = 1'b1;
                w_rs_idx  = SEL_W'(k);
                w_rs_tnew = r_tnew[k];
            end
            if (hz.D_rt_use && (hz.D_rt != '0) && r_valid[k] && (r_a3[k] == hz.D_rt)) begin
                w_rt_hit  = 1'b1;
                w_rt_idx  = SEL_W'(k);
                w_rt_tnew = r_tnew[k];
            end
        end
    end

    assign w_rs_hazard = w_rs_hit && (w_rs_tnew > hz.D_rs_Tuse);
    assign w_rt_hazard = w_rt_hit && (w_rt_tnew > hz.D_rt_Tuse);
    assign w_md_hazard = hz.D_md_use && w_md_busy;
    assign w_stall     = w_rs_hazard || w_rt_hazard || w_md_hazard;

    md_busy_counter #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .i_load (hz.D_md_start && !w_stall),
        .i_div  (hz.D_md_div),
        .o_busy (w_md_busy)
    );

    // A pending result (tnew > 0) is left for a later stage to forward.
    assign hz.fwd_rs_sel = (w_rs_hit && (w_rs_tnew == '0)) ? w_rs_idx : '0;
    assign hz.fwd_rt_sel = (w_rt_hit && (w_rt_tnew == '0)) ? w_rt_idx : '0;
    assign hz.stall      = w_stall;
    assign hz.md_busy    = w_md_busy;

endmodule
